// File: rtl/onehot_scan_sequencer.sv
// Prescaled sequencer driving the 3-to-8 one-hot decoder path: walk-up, walk-down, ping-pong or blink.
// Optional feature macro: SCAN_PAUSE_EN adds a PAUSE input that freezes a running scan.
module onehot_scan_sequencer #(
  parameter int DIV_W   = 8,
  parameter int DIV_MAX = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
`ifdef SCAN_PAUSE_EN
  input  logic       pause,
`endif
  input  logic [1:0] mode,
  input  logic [3:0] cycles,
  output logic [2:0] sel,
  output logic       pat,
  output logic [7:0] out,
  output logic       busy,
  output logic       done
);

  localparam logic [DIV_W-1:0] PRESC_LAST = DIV_W'(DIV_MAX - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] presc;
  logic [1:0]       mode_q;
  logic [3:0]       cycles_q, count, count_step;
  logic             dir, phase;
  logic             paused, tick, advance, finish;
  logic [2:0]       sel_step;
  logic             dir_step, phase_step, pass_wrap;

`ifdef SCAN_PAUSE_EN
  assign paused = pause;
`else
  assign paused = 1'b0;
`endif

  assign tick    = (presc == PRESC_LAST);
  assign advance = (state == RUN) && !paused && tick;
  assign finish  = advance && pass_wrap && (cycles_q != 4'd0) && (count_step == cycles_q);

  // Next position in the sequence; pass_wrap marks the step that returns to the start value.
  always_comb begin
    sel_step   = sel;
    dir_step   = dir;
    phase_step = phase;
    pass_wrap  = 1'b0;
    case (mode_q)
      2'b00: begin
        sel_step  = sel + 3'd1;
        pass_wrap = (sel == 3'd7);
      end
      2'b01: begin
        sel_step  = sel - 3'd1;
        pass_wrap = (sel == 3'd0);
      end
      2'b10: begin
        if (!dir) begin
          if (sel == 3'd7) begin
            sel_step = 3'd6;
            dir_step = 1'b1;
          end else begin
            sel_step = sel + 3'd1;
          end
        end else begin
          sel_step = sel - 3'd1;
          if (sel == 3'd1) begin
            dir_step  = 1'b0;
            pass_wrap = 1'b1;
          end
        end
      end
      2'b11: begin
        phase_step = ~phase;
        pass_wrap  = phase;
      end
    endcase
    count_step = pass_wrap ? count + 4'd1 : count;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start && !stop) state_nx = RUN;
      RUN:  if (stop || finish) state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      sel      <= 3'd0;
      mode_q   <= 2'b00;
      cycles_q <= 4'd0;
      count    <= 4'd0;
      dir      <= 1'b0;
      phase    <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !stop) begin
            mode_q   <= mode;
            cycles_q <= cycles;
            presc    <= '0;
            count    <= 4'd0;
            dir      <= 1'b0;
            phase    <= 1'b0;
            sel      <= (mode == 2'b01) ? 3'd7 : 3'd0;
          end
        end
        RUN: begin
          // STOP outranks a completing step, so DONE only fires on an uninterrupted finish.
          if (stop || finish) begin
            presc <= '0;
            sel   <= 3'd0;
            count <= 4'd0;
            dir   <= 1'b0;
            phase <= 1'b0;
            done  <= !stop;
          end else if (!paused) begin
            if (tick) begin
              presc <= '0;
              sel   <= sel_step;
              dir   <= dir_step;
              phase <= phase_step;
              count <= count_step;
            end else begin
              presc <= presc + DIV_W'(1);
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    busy = (state == RUN);
    pat  = 1'b0;
    out  = 8'h00;
    if (state == RUN) begin
      if (mode_q == 2'b11) begin
        pat = 1'b1;
        out = phase ? 8'hCC : 8'h33;
      end else begin
        out = 8'b1 << sel;
      end
    end
  end

endmodule
